uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART TX FIFO among up to N_REQ byte-stream sources (sweeper results, PLL lock telemetry, status). It wraps each granted packet in a one-byte source header and a one-byte checksum trailer, then drives the FIFO write port (`fifo_data_in`, `fifo_wr_en`) of the UART transmit path. It honours the FIFO's `fifo_full` back-pressure. Packets are never interleaved in the FIFO.

---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/uart_tx_arbiter_if.sv | 12 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM states, header default and checksum helper for the UART TX arbiter.
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;
    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
    function automatic logic [7:0] cksum_trailer(input logic [7:0] sum);
        return 8'h00 - sum;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: per-source byte streams in, FIFO write port out.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_data;
    logic [7:0]         fifo_data_in;
    logic               fifo_wr_en;
    logic               fifo_full;
    modport master(input req_valid, req_last, req_data, fifo_full, output req_ready, fifo_data_in, fifo_wr_en);
    modport slave(output req_valid, req_last, req_data, fifo_full, input req_ready, fifo_data_in, fifo_wr_en);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: first set request at or after ptr, wrapping; purely combinational.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);
    logic [2*N_REQ-1:0] rot;
    logic [IW:0]        sel;
    always_comb begin
        rot   = {req, req} >> ptr;
        found = |rot[N_REQ-1:0];
        sel   = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) sel = {1'b0, ptr} + (IW+1)'(k);
        idx = IW'(sel >= (IW+1)'(N_REQ) ? sel - (IW+1)'(N_REQ) : sel);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter framing each packet as header, payload, checksum
// into the shared UART TX FIFO.
module uart_tx_arbiter import uart_arb_pkg::*; #(
    parameter int         N_REQ    = 4,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEF,
    parameter int         MAX_LEN  = 64,
    localparam int IW = $clog2(N_REQ),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic              clk_50m,
    input  logic              reset,
    uart_tx_arbiter_if.master bus,
    output logic              busy,
    output logic [IW-1:0]     grant_id,
    output logic              err_trunc
);
    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, idx;
    logic [7:0]    sum_q, sum_d, hdr, pay;
    logic [LW-1:0] len_q, len_d;
    logic          found;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (.req(bus.req_valid), .ptr(rr_ptr_q), .found(found), .idx(idx));

    assign hdr      = HDR_BASE | 8'(grant_q);
    assign pay      = bus.req_data[{grant_q, 3'b000} +: 8];
    assign busy     = state_q != IDLE;
    assign grant_id = grant_q;

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        sum_d            = sum_q;
        len_d            = len_q;
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_data_in = 8'h00;
        err_trunc        = 1'b0;
        case (state_q)
            IDLE: begin
                sum_d   = '0;
                len_d   = '0;
                grant_d = found ? idx : grant_q;
                state_d = found ? HEADER : IDLE;
            end
            HEADER: begin
                bus.fifo_data_in = hdr;
                bus.fifo_wr_en   = !bus.fifo_full;
                if (bus.fifo_wr_en) begin
                    sum_d   = sum_q + hdr;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                bus.fifo_data_in       = pay;
                bus.req_ready[grant_q] = !bus.fifo_full;
                bus.fifo_wr_en         = bus.req_valid[grant_q] && !bus.fifo_full;
                if (bus.fifo_wr_en) begin
                    sum_d     = sum_q + pay;
                    len_d     = len_q + 1'b1;
                    // req_last wins over truncation when both land on the same byte
                    err_trunc = !bus.req_last[grant_q] && len_d == LW'(MAX_LEN);
                    state_d   = (bus.req_last[grant_q] || err_trunc) ? CHECKSUM : PAYLOAD;
                end
            end
            CHECKSUM: begin
                bus.fifo_data_in = cksum_trailer(sum_q);
                bus.fifo_wr_en   = !bus.fifo_full;
                if (bus.fifo_wr_en) begin
                    rr_ptr_d = grant_q == IW'(N_REQ - 1) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            sum_q    <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            sum_q    <= sum_d;
            len_q    <= len_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-fed sources plus a byte scoreboard on the FIFO write port.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int MAX_LEN = 64;
    localparam logic [7:0] HDR = 8'hA0;

    logic       clk_50m = 1'b0;
    logic       reset = 1'b1;
    logic       busy, err_trunc;
    logic [1:0] grant_id;
    logic [N-1:0] hold = '0;
    logic [8:0] src_q[N][$];
    logic [7:0] exp_q[$];
    int n_cmp = 0, n_err = 0, cyc = 0, busy_cnt = 0, trunc_cnt = 0, first_wr = -1, last_wr = -1;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();

    uart_tx_arbiter #(.N_REQ(N), .HDR_BASE(HDR), .MAX_LEN(MAX_LEN)) dut (
        .clk_50m(clk_50m), .reset(reset), .bus(bus),
        .busy(busy), .grant_id(grant_id), .err_trunc(err_trunc)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_50m);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant"}, grant_id, 0);
        check({tag, "_trunc"}, err_trunc, 0);
        check({tag, "_wr"}, bus.fifo_wr_en, 0);
        check({tag, "_rdy"}, bus.req_ready, 0);
        check({tag, "_data"}, bus.fifo_data_in, 0);
    endtask

    task automatic clear_all;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        hold = '0;
        bus.fifo_full = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_all();
        repeat (2) tick();
        check_quiet("rst");
        reset = 1'b0;
        tick();
    endtask

    task automatic pkt(input int src, input int n, input logic [7:0] base);
        logic [7:0] sum, b, h;
        int k, m;
        for (int j = 0; j < n; j++) src_q[src].push_back({j == n - 1, 8'(base + 8'(j))});
        k = 0;
        while (k < n) begin
            m = (n - k > MAX_LEN) ? MAX_LEN : n - k;
            h = HDR | 8'(src);
            exp_q.push_back(h);
            sum = h;
            for (int j = 0; j < m; j++) begin
                b = 8'(base + 8'(k + j));
                exp_q.push_back(b);
                sum = sum + b;
            end
            exp_q.push_back(8'h00 - sum);
            k += m;
        end
    endtask

    task automatic wait_left(input int left);
        for (int c = 0; c < 500 && exp_q.size() > left; c++) tick();
        check("wait_left", exp_q.size() <= left, 1);
    endtask

    task automatic drain;
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) tick();
        check("drain", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic clr_stats;
        busy_cnt = 0;
        trunc_cnt = 0;
        first_wr = -1;
        last_wr = -1;
    endtask

    initial begin
        logic [N-1:0] v, l, fire;
        logic [8*N-1:0] d;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk_50m);
            fire = bus.req_valid & bus.req_ready;
            @(posedge clk_50m);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                v[i] = src_q[i].size() > 0 && !hold[i];
                d[8*i +: 8] = src_q[i].size() > 0 ? src_q[i][0][7:0] : 8'h00;
                l[i] = src_q[i].size() > 0 ? src_q[i][0][8] : 1'b0;
            end
            bus.req_valid = v;
            bus.req_data = d;
            bus.req_last = l;
        end
    end

    initial forever begin
        @(negedge clk_50m);
        cyc++;
        if (bus.fifo_full) check("wr_when_full", bus.fifo_wr_en, 0);
        if (bus.fifo_wr_en) begin
            if (exp_q.size() == 0) check("extra_wr", bus.fifo_data_in, 32'hFFFF_FFFF);
            else check("fifo_byte", bus.fifo_data_in, exp_q.pop_front());
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        busy_cnt += int'(busy);
        trunc_cnt += int'(err_trunc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // single source 1 with literal expected frame
        clr_stats();
        src_q[1].push_back({1'b0, 8'h01});
        src_q[1].push_back({1'b0, 8'h02});
        src_q[1].push_back({1'b1, 8'h03});
        exp_q = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h59};
        for (int c = 0; c < 20 && !busy; c++) tick();
        check("s1_grant", grant_id, 1);
        drain();
        check("s1_busy_cycles", busy_cnt, 5);
        check("s1_span", last_wr - first_wr, 4);
        check("s1_no_trunc", trunc_cnt, 0);

        // two contending sources alternate, one bubble between packets
        do_reset();
        clr_stats();
        pkt(0, 1, 8'h10);
        pkt(2, 1, 8'h20);
        pkt(0, 1, 8'h11);
        pkt(2, 1, 8'h21);
        drain();
        check("rr_span", last_wr - first_wr, 14);

        // back-pressure during payload
        do_reset();
        pkt(1, 6, 8'h40);
        wait_left(5);
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_50m);
            check("full_wr", bus.fifo_wr_en, 0);
            check("full_rdy", bus.req_ready, 0);
            check("full_busy", busy, 1);
        end
        tick();
        bus.fifo_full = 1'b0;
        drain();

        // truncation at MAX_LEN, remainder reframed with the same header
        do_reset();
        clr_stats();
        pkt(3, 70, 8'h00);
        drain();
        check("trunc_pulses", trunc_cnt, 1);

        // stalled source keeps the grant while source 0 waits
        do_reset();
        pkt(2, 6, 8'h60);
        for (int c = 0; c < 20 && !(busy && grant_id == 2); c++) tick();
        pkt(0, 2, 8'h70);
        wait_left(8);
        hold[2] = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_50m);
            check("stall_grant", grant_id, 2);
            check("stall_wr", bus.fifo_wr_en, 0);
        end
        tick();
        hold[2] = 1'b0;
        drain();

        // reset mid-payload drops the packet; source 0 then wins
        do_reset();
        pkt(1, 5, 8'h80);
        wait_left(4);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_quiet("mid_rst");
        clear_all();
        pkt(0, 2, 8'h90);
        pkt(1, 2, 8'hB0);
        repeat (2) tick();
        reset = 1'b0;
        for (int c = 0; c < 20 && !busy; c++) tick();
        check("post_rst_grant", grant_id, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
